// File: rtl/spike_addr_encoder_if.sv
// Spike-vector capture and FIFO write-side bundle for the spike address encoder.
// The master drives spikes and the FIFO full flag. The slave (the encoder) drives the write side.
interface spike_addr_encoder_if #(
    parameter int NID_WIDTH  = 7,
    parameter int DATA_WIDTH = 16,
    parameter int DROP_WIDTH = 8
);
    localparam int N = 2**NID_WIDTH;

    logic                  spike_valid;
    logic [N-1:0]          spikes;
    logic                  fifo_full;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic [DROP_WIDTH-1:0] drop_cnt;

    modport master (
        output spike_valid, spikes, fifo_full,
        input  wr, data_out, busy, drop_cnt
    );

    modport slave (
        input  spike_valid, spikes, fifo_full,
        output wr, data_out, busy, drop_cnt
    );
endinterface

// File: rtl/spike_addr_encoder.sv
// Serialises a captured per-timestep spike vector into {timestep, neuron_id} words, one per cycle,
// lowest neuron first, and stalls on FIFO back-pressure.
module spike_addr_encoder #(
    parameter int NID_WIDTH  = 7,
    parameter int DATA_WIDTH = 16,
    parameter int DROP_WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    spike_addr_encoder_if.slave bus
);
    localparam int N        = 2**NID_WIDTH;
    localparam int TS_WIDTH = DATA_WIDTH - NID_WIDTH;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state;
    logic [N-1:0]          pending;
    logic [TS_WIDTH-1:0]   ts;
    logic [DROP_WIDTH-1:0] drop_q;
    logic [NID_WIDTH-1:0]  nid;
    logic [N-1:0]          clr_mask;
    logic [N-1:0]          rest;
    logic                  busy;
    logic                  wr;

    // Lowest set bit wins: scanning from the top, the last hit overrides.
    always_comb begin
        nid = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (pending[i]) nid = NID_WIDTH'(i);
        end
    end

    assign clr_mask = N'(1) << nid;
    assign rest     = pending & ~clr_mask;
    assign busy     = (state == SCAN);
    // Combinational so the full flag is honoured in the cycle it is raised.
    assign wr       = busy & ~bus.fifo_full;

    assign bus.wr       = wr;
    assign bus.busy     = busy;
    assign bus.data_out = {ts, nid};
    assign bus.drop_cnt = drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            ts      <= '0;
            drop_q  <= '0;
        end else begin
            // Timestep counts every strobe, including dropped frames, so later events see the new ts.
            if (bus.spike_valid) begin
                ts <= ts + TS_WIDTH'(1);
                if (busy && drop_q != '1) drop_q <= drop_q + DROP_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.spike_valid && bus.spikes != '0) begin
                        pending <= bus.spikes;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (wr) begin
                        pending <= rest;
                        if (rest == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_addr_encoder.sv
// Randomised bench for spike_addr_encoder, checked cycle by cycle against a queue-of-events model.
module tb_spike_addr_encoder;
    localparam int NW = 7;
    localparam int N  = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spike_addr_encoder_if bus();
    spike_addr_encoder dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    // Model: outstanding events as a queue of neuron ids, plus timestep and drop count.
    int          m_q[$];
    int          m_ts = 0;
    int          m_drop = 0;
    logic        exp_wr, exp_busy;
    logic [15:0] exp_data;
    logic [7:0]  exp_drop;
    logic [15:0] wlog[$];

    task automatic drive(input logic sv, input logic [N-1:0] sp, input logic ff);
        bus.spike_valid = sv;
        bus.spikes      = sp;
        bus.fifo_full   = ff;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ts   = 0;
        m_drop = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        exp_busy = (m_q.size() > 0);
        exp_wr   = exp_busy && !bus.fifo_full;
        exp_data = 16'((m_ts << NW) | (exp_busy ? m_q[0] : 0));
        exp_drop = 8'(m_drop);
        if (bus.wr === 1'b1) wlog.push_back(bus.data_out);
    endtask

    task automatic tick();
        bit was_busy;
        was_busy = (m_q.size() > 0);
        if (exp_wr) void'(m_q.pop_front());
        if (bus.spike_valid) begin
            m_ts = (m_ts + 1) % 512;
            if (was_busy) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else for (int i = 0; i < N; i++) if (bus.spikes[i]) m_q.push_back(i);
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_spikes();
        logic [N-1:0] a, b, c;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        return a & b & c;
    endfunction

    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        n_total += 4;
        if (bus.wr !== 1'b0)        $display("FAIL reset_wr got %b want 0", bus.wr); else n_pass++;
        if (bus.data_out !== 16'h0) $display("FAIL reset_data got %h want 0000", bus.data_out); else n_pass++;
        if (bus.busy !== 1'b0)      $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        if (bus.drop_cnt !== 8'h0)  $display("FAIL reset_drop got %0d want 0", bus.drop_cnt); else n_pass++;
        model_reset();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            n_total += 2;
            if (bus.wr !== exp_wr)     $display("FAIL reset_idle_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.busy !== exp_busy) $display("FAIL reset_idle_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            tick();
        end
    endtask

    task automatic test_basic();
        wlog.delete();
        for (int c = 0; c < 6; c++) begin
            drive(c == 0, (c == 0) ? 128'h85 : '0, 1'b0);
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL basic_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL basic_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL basic_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL basic_drop c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            tick();
        end
        n_total++;
        if (wlog.size() != 3 || wlog[0] !== 16'h0080 || wlog[1] !== 16'h0082 || wlog[2] !== 16'h0087)
            $display("FAIL basic_seq got %p want 0080 0082 0087", wlog);
        else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        wlog.delete();
        for (int c = 0; c < 9; c++) begin
            drive(c == 0, (c == 0) ? 128'h85 : '0, (c >= 2 && c <= 4));
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL stall_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL stall_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL stall_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL stall_drop c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            if (c >= 2 && c <= 4) begin
                n_total++;
                if (bus.data_out !== 16'h0082 || bus.wr !== 1'b0)
                    $display("FAIL stall_hold c%0d got wr=%b data=%h want wr=0 data=0082", c, bus.wr, bus.data_out);
                else n_pass++;
            end
            tick();
        end
        n_total++;
        if (wlog.size() != 3 || wlog[0] !== 16'h0080 || wlog[1] !== 16'h0082 || wlog[2] !== 16'h0087)
            $display("FAIL stall_seq got %p want 0080 0082 0087", wlog);
        else n_pass++;
    endtask

    task automatic test_drop();
        apply_reset();
        wlog.delete();
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(1'b1, 128'h5B, 1'b0);
            else if (c == 1) drive(1'b1, rnd_spikes() | 128'h1, 1'b0);
            else             drive(1'b0, '0, 1'b0);
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL drop_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL drop_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL drop_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL drop_cnt c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            tick();
        end
        n_total += 2;
        if (bus.drop_cnt !== 8'd1) $display("FAIL drop_final got %0d want 1", bus.drop_cnt); else n_pass++;
        if (wlog.size() != 5 || wlog[0] !== 16'h0080 || wlog[1] !== 16'h0101 || wlog[2] !== 16'h0103 ||
            wlog[3] !== 16'h0104 || wlog[4] !== 16'h0106)
            $display("FAIL drop_seq got %p want 0080 0101 0103 0104 0106", wlog);
        else n_pass++;
    endtask

    task automatic test_ts_wrap();
        apply_reset();
        wlog.delete();
        for (int c = 0; c < 515; c++) begin
            if (c < 511)       drive(1'b1, '0, 1'b0);
            else if (c == 511) drive(1'b1, 128'h20, 1'b0);
            else               drive(1'b0, '0, 1'b0);
            sample();
            n_total += 3;
            if (bus.wr !== exp_wr)         $display("FAIL wrap_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL wrap_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL wrap_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            tick();
        end
        n_total++;
        if (wlog.size() != 1 || wlog[0] !== 16'h0005) $display("FAIL wrap_event got %p want 0005", wlog); else n_pass++;
    endtask

    task automatic test_drop_sat();
        apply_reset();
        for (int c = 0; c < 434; c++) begin
            if (c == 0)        drive(1'b1, '1, 1'b1);
            else if (c <= 300) drive(1'b1, rnd_spikes(), 1'b1);
            else               drive(1'b0, '0, 1'b0);
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL sat_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL sat_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL sat_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL sat_drop c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            tick();
        end
        n_total++;
        if (bus.drop_cnt !== 8'd255) $display("FAIL sat_final got %0d want 255", bus.drop_cnt); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if (c < 600) drive(($urandom_range(7) == 0), ($urandom_range(5) == 0) ? '0 : rnd_spikes(),
                               ($urandom_range(2) == 0));
            else         drive(1'b0, '0, 1'b0);
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL rnd_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL rnd_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL rnd_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL rnd_drop c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int writes = 0;
        int c = 0;
        apply_reset();
        wlog.delete();
        while (writes < 40 && c < 1000) begin
            drive((c == 0 || c == 10), (c == 0) ? '1 : rnd_spikes(), (c != 0) && ($urandom_range(2) == 0));
            sample();
            n_total += 4;
            if (bus.wr !== exp_wr)         $display("FAIL mid_wr c%0d got %b want %b", c, bus.wr, exp_wr); else n_pass++;
            if (bus.data_out !== exp_data) $display("FAIL mid_data c%0d got %h want %h", c, bus.data_out, exp_data); else n_pass++;
            if (bus.busy !== exp_busy)     $display("FAIL mid_busy c%0d got %b want %b", c, bus.busy, exp_busy); else n_pass++;
            if (bus.drop_cnt !== exp_drop) $display("FAIL mid_drop c%0d got %0d want %0d", c, bus.drop_cnt, exp_drop); else n_pass++;
            if (exp_wr) writes++;
            tick();
            c++;
        end
        n_total++;
        if (writes < 40) $display("FAIL mid_budget got %0d writes want 40", writes); else n_pass++;
        reset = 1'b1;
        model_reset();
        drive(1'b0, '0, 1'b0);
        #1;
        n_total += 4;
        if (bus.wr !== 1'b0)        $display("FAIL mid_rst_wr got %b want 0", bus.wr); else n_pass++;
        if (bus.data_out !== 16'h0) $display("FAIL mid_rst_data got %h want 0000", bus.data_out); else n_pass++;
        if (bus.busy !== 1'b0)      $display("FAIL mid_rst_busy got %b want 0", bus.busy); else n_pass++;
        if (bus.drop_cnt !== 8'h0)  $display("FAIL mid_rst_drop got %0d want 0", bus.drop_cnt); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.wr === 1'b1) wlog.push_back(bus.data_out);
            n_total++;
            if (bus.wr !== 1'b0) $display("FAIL mid_hold_wr k%0d got %b want 0", k, bus.wr); else n_pass++;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            n_total += 2;
            if (bus.wr !== exp_wr)     $display("FAIL mid_post_wr k%0d got %b want %b", k, bus.wr, exp_wr); else n_pass++;
            if (bus.busy !== exp_busy) $display("FAIL mid_post_busy k%0d got %b want %b", k, bus.busy, exp_busy); else n_pass++;
            tick();
        end
        n_total++;
        if (wlog.size() != 40) $display("FAIL mid_count got %0d writes want 40", wlog.size()); else n_pass++;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_ts_wrap();
        test_drop_sat();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
